// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: UART TX datapath. Captures the payload and parity type, shifts
// the payload LSB-first and muxes start/data/parity/stop onto a registered serial line.
module uart_tx_serializer #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  ser_en,
    input  logic [1:0]            mux_sel,
    output logic                  ser_done,
    output logic                  TX_OUT
);
    localparam int               CNT_W     = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DATA_WIDTH - 1);
    localparam logic [1:0]       SEL_STOP  = 2'b00;
    localparam logic [1:0]       SEL_START = 2'b01;
    localparam logic [1:0]       SEL_PAR   = 2'b10;
    localparam logic [1:0]       SEL_DATA  = 2'b11;

    logic [DATA_WIDTH-1:0] shift_reg_q, shift_reg_d;
    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic                  par_bit_q, par_bit_d;
    logic                  par_typ_q, par_typ_d;
    logic                  tx_out_q, tx_out_d;
    logic                  load;
    logic                  shift;
    logic                  unused_inputs;

    // Capture only while the FSM sits in IDLE or STOP, so mid-frame strobes are ignored.
    assign load     = Data_Valid & ~ser_en & (mux_sel == SEL_STOP);
    assign shift    = ser_en & (mux_sel == SEL_DATA);
    assign ser_done = shift & (bit_cnt_q == LAST_BIT);
    assign TX_OUT   = tx_out_q;

    // Parity enable is acted on by the FSM (it decides whether to visit the parity slot).
    assign unused_inputs = PAR_EN ^ par_typ_q;

    always_comb begin
        shift_reg_d = shift_reg_q;
        par_bit_d   = par_bit_q;
        par_typ_d   = par_typ_q;
        bit_cnt_d   = bit_cnt_q;
        tx_out_d    = 1'b1;

        if (load) begin
            shift_reg_d = P_DATA;
            par_typ_d   = PAR_TYP;
            par_bit_d   = PAR_TYP ? ~(^P_DATA) : (^P_DATA);
        end else if (shift) begin
            shift_reg_d = shift_reg_q >> 1;
        end

        if (mux_sel != SEL_DATA) begin
            bit_cnt_d = '0;
        end else if (shift) begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end

        case (mux_sel)
            SEL_STOP:  tx_out_d = 1'b1;
            SEL_START: tx_out_d = 1'b0;
            SEL_DATA:  tx_out_d = shift_reg_q[0];
            SEL_PAR:   tx_out_d = par_bit_q;
            default:   tx_out_d = 1'b1;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            shift_reg_q <= '0;
            bit_cnt_q   <= '0;
            par_bit_q   <= 1'b0;
            par_typ_q   <= 1'b0;
            tx_out_q    <= 1'b1;
        end else begin
            shift_reg_q <= shift_reg_d;
            bit_cnt_q   <= bit_cnt_d;
            par_bit_q   <= par_bit_d;
            par_typ_q   <= par_typ_d;
            tx_out_q    <= tx_out_d;
        end
    end
endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb_uart_tx_serializer: drives the FSM-side controls frame by frame and checks the
// serial line against a queue of expected bits built from each captured byte.
module tb_uart_tx_serializer;
    localparam int W = 8;

    logic         CLK = 1'b0;
    logic         RST;
    logic [W-1:0] P_DATA;
    logic         Data_Valid;
    logic         PAR_EN;
    logic         PAR_TYP;
    logic         ser_en;
    logic [1:0]   mux_sel;
    logic         ser_done;
    logic         TX_OUT;

    int   checks = 0;
    int   errors = 0;
    logic exp_q[$];
    logic last_par;

    uart_tx_serializer #(.DATA_WIDTH(W)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .P_DATA     (P_DATA),
        .Data_Valid (Data_Valid),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .ser_en     (ser_en),
        .mux_sel    (mux_sel),
        .ser_done   (ser_done),
        .TX_OUT     (TX_OUT)
    );

    always #5 CLK = ~CLK;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected line bits for one frame: start, data LSB-first, optional parity, stop.
    task automatic push_frame(input logic [W-1:0] d, input logic pen, input logic ptyp);
        int ones = 0;
        exp_q.push_back(1'b0);
        for (int i = 0; i < W; i++) begin
            exp_q.push_back(d[i]);
            if (d[i]) ones++;
        end
        last_par = (ones % 2 == 1) ^ ptyp;
        if (pen) exp_q.push_back(last_par);
        exp_q.push_back(1'b1);
    endtask

    task automatic cycle(input logic [1:0] ms, input logic en, input logic dv,
                         input logic [W-1:0] pd, input logic pt, input logic pop,
                         input logic exp_tx, input logic exp_done, input string tag);
        @(negedge CLK);
        mux_sel = ms; ser_en = en; Data_Valid = dv; P_DATA = pd; PAR_TYP = pt;
        #1 check_val({tag, "_done"}, ser_done, exp_done);
        @(posedge CLK);
        #1;
        if (pop) begin
            check_val("sb_nonempty", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) check_val({tag, "_tx"}, TX_OUT, exp_q.pop_front());
        end else begin
            check_val({tag, "_tx"}, TX_OUT, exp_tx);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(2'b00, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0, "idle");
    endtask

    task automatic load(input logic [W-1:0] d, input logic pen, input logic ptyp);
        PAR_EN = pen;
        push_frame(d, pen, ptyp);
        cycle(2'b00, 1'b0, 1'b1, d, ptyp, 1'b0, 1'b1, 1'b0, "load");
    endtask

    // garb drives a conflicting byte and parity type on every in-frame cycle.
    task automatic run_frame(input logic pen, input logic garb, input logic nxt,
                             input logic [W-1:0] nd, input logic npen, input logic npt);
        logic [W-1:0] gd;
        gd = garb ? {W{1'b1}} : '0;
        cycle(2'b01, 1'b1, garb, gd, garb, 1'b1, 1'b0, 1'b0, "start");
        for (int i = 0; i < W; i++)
            cycle(2'b11, 1'b1, garb, gd, garb, 1'b1, 1'b0, (i == W - 1), "data");
        if (pen) cycle(2'b10, 1'b0, garb, gd, garb, 1'b1, 1'b0, 1'b0, "par");
        if (nxt) begin
            PAR_EN = npen;
            push_frame(nd, npen, npt);
        end
        cycle(2'b00, 1'b0, nxt, nxt ? nd : '0, npt, 1'b1, 1'b0, 1'b0, "stop");
    endtask

    initial begin
        RST = 1'b0; P_DATA = 8'hFF; Data_Valid = 1'b1; PAR_EN = 1'b0; PAR_TYP = 1'b0;
        ser_en = 1'b0; mux_sel = 2'b00; last_par = 1'b0;
        #12;
        check_val("rst_tx", TX_OUT, 1);
        check_val("rst_done", ser_done, 0);
        @(negedge CLK);
        RST = 1'b1; Data_Valid = 1'b0;
        idle(2);

        load(8'hA5, 1'b1, 1'b0);
        run_frame(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        idle(1);

        load(8'hA5, 1'b1, 1'b1);
        run_frame(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        idle(1);
        load(8'h01, 1'b1, 1'b0);
        run_frame(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        idle(1);

        load(8'h3C, 1'b0, 1'b0);
        run_frame(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        // Illegal control combinations: no capture, line follows mux_sel.
        cycle(2'b10, 1'b1, 1'b0, '0, 1'b0, 1'b0, last_par, 1'b0, "ill_par");
        cycle(2'b00, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0, "ill_idle");
        cycle(2'b10, 1'b1, 1'b0, '0, 1'b0, 1'b0, last_par, 1'b0, "ill_par2");
        idle(1);

        load(8'h96, 1'b1, 1'b1);
        run_frame(1'b1, 1'b0, 1'b1, 8'h55, 1'b1, 1'b0);
        run_frame(1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b0);
        idle(1);

        load(8'h5A, 1'b1, 1'b0);
        cycle(2'b01, 1'b1, 1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0, "start");
        for (int i = 0; i < 3; i++)
            cycle(2'b11, 1'b1, 1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0, "data");
        @(negedge CLK);
        mux_sel = 2'b11; ser_en = 1'b1; Data_Valid = 1'b0;
        #2 RST = 1'b0;
        #1;
        check_val("rst_mid_tx", TX_OUT, 1);
        check_val("rst_mid_done", ser_done, 0);
        exp_q.delete();
        @(negedge CLK);
        mux_sel = 2'b00; ser_en = 1'b0;
        RST = 1'b1;
        idle(1);
        load(8'hC3, 1'b1, 1'b0);
        run_frame(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        idle(2);
        check_val("sb_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
